// File: rtl/test021_test.sv
// Self-test block: fills a 16-entry memory with i*i, reads it back through a
// registered read port, and reports whether the sum and maximum match 1240/225.
module test021_test (
    input  logic clk,
    input  logic reset,
    input  logic test_req,
    output logic test_busy,
    output logic test_return
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_SUM   = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [31:0] EXP_SUM = 32'd1240;
    localparam logic [31:0] EXP_MAX = 32'd225;

    logic [2:0]  state_q, state_d;
    logic [4:0]  i_q, i_d;
    logic [31:0] sum_q, sum_d;
    logic [31:0] maxv_q, maxv_d;
    logic        ret_q, ret_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [16];
    logic [31:0] idx_ext;
    logic        mem_we;

    assign idx_ext = {28'd0, i_q[3:0]};
    assign mem_we  = (state_q == ST_INIT);

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        sum_d    = sum_q;
        maxv_d   = maxv_q;
        ret_d    = ret_q;
        rvalid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (test_req) begin
                    i_d     = 5'd0;
                    sum_d   = 32'd0;
                    maxv_d  = 32'd0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (i_q == 5'd15) begin
                    i_d     = 5'd0;
                    state_d = ST_SUM;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            ST_SUM: begin
                // Accumulate the word addressed on the previous cycle.
                if (rvalid_q) begin
                    sum_d  = sum_q + rdata_q;
                    maxv_d = (rdata_q > maxv_q) ? rdata_q : maxv_q;
                end
                if (i_q <= 5'd15) begin
                    i_d      = i_q + 5'd1;
                    rvalid_d = 1'b1;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                ret_d   = (sum_q == EXP_SUM) && (maxv_q == EXP_MAX);
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            i_q      <= 5'd0;
            sum_q    <= 32'd0;
            maxv_q   <= 32'd0;
            ret_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            sum_q    <= sum_d;
            maxv_q   <= maxv_d;
            ret_q    <= ret_d;
            rvalid_q <= rvalid_d;
        end
    end

    // NOTE: the memory and its read register have no reset; INIT rewrites every entry before any read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[i_q[3:0]] <= idx_ext * idx_ext;
        end
        rdata_q <= mem_q[i_q[3:0]];
    end

    assign test_busy   = (state_q == ST_INIT) || (state_q == ST_SUM) || (state_q == ST_CHECK);
    assign test_return = ret_q;

endmodule

// File: tb/tb_test021_test.sv
// Bench for test021_test: directed scenarios plus randomized request/reset
// traffic, checked every cycle against a run-counter reference model.
module tb_test021_test;

    logic clk;
    logic reset;
    logic test_req;
    logic test_busy;
    logic test_return;

    int errors = 0;
    int checks = 0;

    // Reference model: a run is 34 busy cycles, then one DONE cycle, then IDLE.
    int          busy_cnt = 0;
    bit          in_done  = 1'b0;
    bit          m_ret    = 1'b0;
    logic [31:0] mem_model [16];

    test021_test dut (
        .clk        (clk),
        .reset      (reset),
        .test_req   (test_req),
        .test_busy  (test_busy),
        .test_return(test_return)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit expected_pass();
        longint s = 0;
        longint m = 0;
        for (int k = 0; k < 16; k++) begin
            s += mem_model[k];
            if (mem_model[k] > m) m = mem_model[k];
        end
        return (s % (64'd1 << 32) == 1240) && (m == 225);
    endfunction

    task automatic model_step(input logic r, input logic q);
        if (r) begin
            busy_cnt = 0;
            in_done  = 1'b0;
            m_ret    = 1'b0;
        end else if (busy_cnt > 0) begin
            if (busy_cnt == 34) begin
                busy_cnt = 0;
                in_done  = 1'b1;
                m_ret    = expected_pass();
            end else begin
                busy_cnt++;
            end
        end else if (in_done) begin
            in_done = 1'b0;
        end else if (q) begin
            busy_cnt = 1;
            for (int k = 0; k < 16; k++) mem_model[k] = 32'(k * k);
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare on the falling edge.
    task automatic cycle(input logic r, input logic q);
        reset    = r;
        test_req = q;
        @(posedge clk);
        model_step(r, q);
        @(negedge clk);
        check("busy", int'(test_busy), busy_cnt > 0 ? 1 : 0);
        check("return", int'(test_return), int'(m_ret));
    endtask

    task automatic run_until_done(input logic q);
        for (int n = 0; n < 100 && !in_done; n++) cycle(1'b0, q);
    endtask

    initial begin
        int dones;
        logic rq;
        reset    = 1'b1;
        test_req = 1'b0;

        // Reset for 6 cycles, then a quiet idle period.
        for (int n = 0; n < 6; n++) cycle(1'b1, 1'b0);
        for (int n = 0; n < 100; n++) cycle(1'b0, 1'b0);

        // Held request: one full run.
        run_until_done(1'b1);
        check("held_run_ret", int'(test_return), 1);
        for (int n = 0; n < 45; n++) cycle(1'b0, 1'b0);

        // Single-cycle pulse: exactly one run, no restart.
        cycle(1'b0, 1'b1);
        for (int n = 0; n < 60; n++) cycle(1'b0, 1'b0);
        check("pulse_ret", int'(test_return), 1);
        check("pulse_idle", int'(test_busy), 0);

        // Request held through three back-to-back runs.
        dones = 0;
        for (int n = 0; n < 200 && dones < 3; n++) begin
            cycle(1'b0, 1'b1);
            if (in_done) dones++;
        end
        check("three_runs", dones, 3);
        for (int n = 0; n < 45; n++) cycle(1'b0, 1'b0);

        // Reset at the 10th busy cycle aborts the run and clears the result.
        cycle(1'b0, 1'b1);
        for (int n = 0; n < 20 && busy_cnt != 10; n++) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("abort_busy", int'(test_busy), 0);
        check("abort_ret", int'(test_return), 0);
        cycle(1'b0, 1'b1);
        run_until_done(1'b0);
        check("after_abort_ret", int'(test_return), 1);
        for (int n = 0; n < 5; n++) cycle(1'b0, 1'b0);

        // Corrupt mem[3] after INIT, before it is read: the run must report failure.
        cycle(1'b0, 1'b1);
        for (int n = 0; n < 30 && busy_cnt != 17; n++) cycle(1'b0, 1'b0);
        dut.mem_q[3] = 32'd10;
        mem_model[3] = 32'd10;
        run_until_done(1'b0);
        check("corrupt_ret", int'(test_return), 0);
        for (int n = 0; n < 5; n++) cycle(1'b0, 1'b0);

        // Randomized request levels with occasional resets.
        rq = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) rq = ~rq;
            cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rq);
        end
        for (int n = 0; n < 50; n++) cycle(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
